// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// int_ctrl : two-level prioritised interrupt controller with nesting depth 2
// Rev 1.0
// ============================================================================
module int_ctrl #(
  parameter int          N_SRC      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int          VEC_STRIDE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_req,
  input  logic             i_ea,
  input  logic [N_SRC-1:0] i_ie,
  input  logic [N_SRC-1:0] i_ip,
  input  logic             i_ack,
  input  logic             i_reti,
  output logic             o_irq,
  output logic [15:0]      o_vector,
  output logic [2:0]       o_src,
  output logic             o_busy,
  output logic [1:0]       o_lvl_act
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [2:0]         src_q, src_d;
  logic               lvl_q, lvl_d;
  logic [15:0]        vector_q, vector_d;
  logic               hi_act_q, hi_act_d;
  logic               lo_act_q, lo_act_d;
  logic               busy_q, busy_d;

  logic [N_SRC-1:0]   elig;
  logic [N_SRC-1:0]   clr;
  logic               found_hi, found_lo;
  logic [2:0]         hi_idx, lo_idx, win_idx;
  logic               frozen_elig;
  logic               ack_take;

  // Level gate: a high ISR blocks everything, a low ISR admits only high sources.
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_SRC; k++) begin
      elig[k] = pend_q[k] & i_ie[k] & i_ea &
                (hi_act_q ? 1'b0 : (lo_act_q ? i_ip[k] : 1'b1));
    end
  end

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (elig[k]) begin
        if (i_ip[k]) begin
          found_hi = 1'b1;
          hi_idx   = 3'(k);
        end else begin
          found_lo = 1'b1;
          lo_idx   = 3'(k);
        end
      end
    end
    win_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    frozen_elig = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (src_q == 3'(k)) frozen_elig = elig[k];
    end
  end

  assign ack_take = (state_q == S_OFFER) & i_ack;

  always_comb begin
    clr = '0;
    for (int k = 0; k < N_SRC; k++) begin
      clr[k] = ack_take & (src_q == 3'(k));
    end
    // A new request on the acknowledge edge must survive the clear.
    pend_d = i_req | (pend_q & ~clr);
  end

  // RETI retires the innermost level first; the acknowledge then opens a new one.
  always_comb begin
    hi_act_d = hi_act_q;
    lo_act_d = lo_act_q;
    if (i_reti) begin
      if (hi_act_q)      hi_act_d = 1'b0;
      else if (lo_act_q) lo_act_d = 1'b0;
    end
    if (ack_take) begin
      if (lvl_q) hi_act_d = 1'b1;
      else       lo_act_d = 1'b1;
    end
    busy_d = hi_act_d | lo_act_d;
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    lvl_d    = lvl_q;
    vector_d = vector_q;
    case (state_q)
      S_IDLE: begin
        if (found_hi | found_lo) begin
          state_d  = S_OFFER;
          src_d    = win_idx;
          lvl_d    = found_hi;
          vector_d = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, win_idx};
        end
      end
      S_OFFER: begin
        // An acknowledge wins over a same-cycle withdrawal: the CPU already took it.
        if (ack_take || !frozen_elig) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      src_q    <= '0;
      lvl_q    <= 1'b0;
      vector_q <= 16'h0000;
      hi_act_q <= 1'b0;
      lo_act_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      src_q    <= src_d;
      lvl_q    <= lvl_d;
      vector_q <= vector_d;
      hi_act_q <= hi_act_d;
      lo_act_q <= lo_act_d;
      busy_q   <= busy_d;
    end
  end

  assign o_irq     = (state_q == S_OFFER);
  assign o_src     = src_q;
  assign o_vector  = vector_q;
  assign o_busy    = busy_q;
  assign o_lvl_act = {hi_act_q, lo_act_q};

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// tb_int_ctrl : directed scenarios plus randomized run against a reference model
// Rev 1.0
// ============================================================================
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req = '0;
  logic        ea = 1'b0;
  logic [4:0]  ie = '0;
  logic [4:0]  ip = '0;
  logic        ack = 1'b0;
  logic        reti = 1'b0;
  logic        irq;
  logic [15:0] vec;
  logic [2:0]  src;
  logic        busy;
  logic [1:0]  lvl_act;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [4:0]  m_pend = '0;
  logic        m_hi = 1'b0, m_lo = 1'b0, m_offer = 1'b0, m_lvl = 1'b0;
  logic [2:0]  m_src = '0;
  logic [15:0] m_vec = '0;

  int_ctrl dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_ea     (ea),
    .i_ie     (ie),
    .i_ip     (ip),
    .i_ack    (ack),
    .i_reti   (reti),
    .o_irq    (irq),
    .o_vector (vec),
    .o_src    (src),
    .o_busy   (busy),
    .o_lvl_act(lvl_act)
  );

  always #5 clk = ~clk;

  function automatic bit m_elig(int k);
    if (!(m_pend[k] && ie[k] && ea)) return 1'b0;
    if (m_hi) return 1'b0;
    if (m_lo) return ip[k];
    return 1'b1;
  endfunction

  // One clock: model next state from the inputs held across the edge.
  task automatic tick();
    logic [4:0]  np;
    logic        nhi, nlo, noff, nlvl;
    logic [2:0]  nsrc;
    logic [15:0] nvec;
    bit          acc;
    int          w;
    np = m_pend; nhi = m_hi; nlo = m_lo; noff = m_offer;
    nsrc = m_src; nlvl = m_lvl; nvec = m_vec;
    acc = m_offer && ack;
    if (reti) begin
      if (m_hi) nhi = 1'b0;
      else if (m_lo) nlo = 1'b0;
    end
    if (acc) begin
      if (m_lvl) nhi = 1'b1;
      else nlo = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      if (req[k]) np[k] = 1'b1;
      else if (acc && m_src == 3'(k)) np[k] = 1'b0;
    end
    if (m_offer) begin
      if (acc || !m_elig(int'(m_src))) noff = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < 5; k++) if (w < 0 && m_elig(k) && ip[k]) w = k;
      for (int k = 0; k < 5; k++) if (w < 0 && m_elig(k)) w = k;
      if (w >= 0) begin
        noff = 1'b1;
        nsrc = 3'(w);
        nlvl = ip[w];
        nvec = 16'h0003 + 16'(w * 8);
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_pend = '0; m_hi = 0; m_lo = 0; m_offer = 0; m_src = '0; m_lvl = 0; m_vec = '0;
    end else begin
      m_pend = np; m_hi = nhi; m_lo = nlo; m_offer = noff; m_src = nsrc; m_lvl = nlvl; m_vec = nvec;
    end
  endtask

  task automatic apply_reset();
    req = '0; ack = 0; reti = 0; ea = 0; ie = '0; ip = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (!irq && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL %s: o_irq=%b after %0d cycles, required 1", name, irq, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({irq, busy, lvl_act, src, vec, dut.pend_q} !== 29'd0) begin
      failures++;
      $display("FAIL reset_state: irq=%b busy=%b lvl=%b src=%0d vec=%h pend=%b, required all 0",
               irq, busy, lvl_act, src, vec, dut.pend_q);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b00100;
    tick();
    req = '0;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL single_n1: o_irq=%b, required 0", irq);
    end
    tick();
    checks++;
    if ({irq, src, vec} !== {1'b1, 3'd2, 16'h0013}) begin
      failures++; $display("FAIL single_n2: irq=%b src=%0d vec=%h, required 1 2 0013", irq, src, vec);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if ({irq, dut.pend_q[2], busy, lvl_act} !== {1'b0, 1'b0, 1'b1, 2'b01}) begin
      failures++;
      $display("FAIL single_ack: irq=%b pend2=%b busy=%b lvl=%b, required 0 0 1 01",
               irq, dut.pend_q[2], busy, lvl_act);
    end
    reti = 1;
    tick();
    reti = 0;
    checks++;
    if ({busy, lvl_act} !== 3'b000) begin
      failures++; $display("FAIL single_reti: busy=%b lvl=%b, required 0 00", busy, lvl_act);
    end
  endtask

  task automatic test_two_pending();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b01010;
    tick();
    req = '0;
    tick();
    checks++;
    if ({irq, src, vec} !== {1'b1, 3'd1, 16'h000B}) begin
      failures++; $display("FAIL two_first: irq=%b src=%0d vec=%h, required 1 1 000b", irq, src, vec);
    end
    ack = 1; tick(); ack = 0;
    reti = 1; tick(); reti = 0;
    wait_irq("two_second_wait");
    checks++;
    if ({src, vec} !== {3'd3, 16'h001B}) begin
      failures++; $display("FAIL two_second: src=%0d vec=%h, required 3 001b", src, vec);
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b10000; tick(); req = '0;
    wait_irq("pre_low_wait");
    checks++;
    if (src !== 3'd4) begin
      failures++; $display("FAIL pre_low_src: src=%0d, required 4", src);
    end
    ack = 1; tick(); ack = 0;
    ip = 5'b00001;
    req = 5'b00001; tick(); req = '0;
    wait_irq("pre_high_wait");
    checks++;
    if ({src, vec} !== {3'd0, 16'h0003}) begin
      failures++; $display("FAIL pre_high: src=%0d vec=%h, required 0 0003", src, vec);
    end
    ack = 1; tick(); ack = 0;
    checks++;
    if (lvl_act !== 2'b11) begin
      failures++; $display("FAIL pre_nested: lvl=%b, required 11", lvl_act);
    end
    reti = 1; tick(); reti = 0;
    checks++;
    if (lvl_act !== 2'b01) begin
      failures++; $display("FAIL pre_reti1: lvl=%b, required 01", lvl_act);
    end
    reti = 1; tick(); reti = 0;
    checks++;
    if ({lvl_act, busy} !== 3'b000) begin
      failures++; $display("FAIL pre_reti2: lvl=%b busy=%b, required 00 0", lvl_act, busy);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b00010; tick(); req = '0;
    wait_irq("wd_wait");
    ie = 5'h1D;
    tick();
    checks++;
    if ({irq, dut.pend_q[1]} !== 2'b01) begin
      failures++; $display("FAIL wd_drop: irq=%b pend1=%b, required 0 1", irq, dut.pend_q[1]);
    end
    ie = 5'h1F;
    wait_irq("wd_reoffer_wait");
    checks++;
    if (src !== 3'd1) begin
      failures++; $display("FAIL wd_reoffer: src=%0d, required 1", src);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b01000; tick(); req = '0;
    wait_irq("b2b_wait");
    ack = 1; req = 5'b01000;
    tick();
    ack = 0; req = '0;
    checks++;
    if ({irq, dut.pend_q[3], lvl_act} !== 4'b0101) begin
      failures++;
      $display("FAIL b2b_ack: irq=%b pend3=%b lvl=%b, required 0 1 01", irq, dut.pend_q[3], lvl_act);
    end
    reti = 1; tick(); reti = 0;
    wait_irq("b2b_reoffer_wait");
    checks++;
    if (src !== 3'd3) begin
      failures++; $display("FAIL b2b_reoffer: src=%0d, required 3", src);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    req = 5'b00100; tick(); req = '0;
    wait_irq("ar_low_wait");
    ack = 1; tick(); ack = 0;
    ip = 5'b00010;
    req = 5'b00010; tick(); req = '0;
    wait_irq("ar_high_wait");
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({irq, busy, lvl_act, dut.pend_q} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset: irq=%b busy=%b lvl=%b pend=%b, required all 0",
               irq, busy, lvl_act, dut.pend_q);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [28:0] got, want;
    int          bad = 0;
    apply_reset();
    ea = 1; ie = 5'h1F; ip = 5'h00;
    for (int c = 0; c < 600; c++) begin
      req  = 5'($urandom) & 5'($urandom) & 5'($urandom);
      ack  = ($urandom_range(0, 99) < 35);
      reti = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 9) == 0) ie = 5'($urandom) | 5'($urandom);
      if ($urandom_range(0, 9) == 0) ip = 5'($urandom);
      if ($urandom_range(0, 19) == 0) ea = ~ea;
      else if (!ea && $urandom_range(0, 3) == 0) ea = 1;
      tick();
      got  = {irq, src, vec, busy, lvl_act, dut.pend_q};
      want = {m_offer, m_src, m_vec, m_hi | m_lo, m_hi, m_lo, m_pend};
      checks++;
      if (got !== want) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_c%0d: irq/src/vec/busy/lvl/pend=%h, required %h", c, got, want);
        bad++;
      end
    end
    req = '0; ack = 0; reti = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pending();
    test_preempt();
    test_withdraw();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, 5, number of interrupt sources; index 0 = highest natural priority.
REQ-002 Parameter VEC_BASE, 16'h0003, vector address of source 0.
REQ-003 Parameter VEC_STRIDE, 8, vector spacing; vector(k) = VEC_BASE + k*VEC_STRIDE.
REQ-004 i_clk  in  1  clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  N_SRC  one-cycle request pulses from the per-source edge-detect stages.
REQ-007 i_ea  in  1  global interrupt enable.
REQ-008 i_ie  in  N_SRC  per-source enable.
REQ-009 i_ip  in  N_SRC  per-source priority level; 1 = high, 0 = low.
REQ-010 i_ack  in  1  CPU accepts the offered vector at an instruction boundary.
REQ-011 i_reti  in  1  CPU executed RETI; one-cycle pulse.
REQ-012 o_irq  out  1  interrupt offered to CPU.
REQ-013 o_vector  out  16  ISR address of offered source.
REQ-014 o_src  out  3  index of offered source.
REQ-015 o_busy  out  1  any ISR in service; drives the edge-detect stages' in-progress input.
REQ-016 o_lvl_act  out  2  in-service flags {high, low}.

Function
REQ-017 pend[k] SHALL set on the rising edge following i_req[k]=1 and clear on the edge where source k is acknowledged; simultaneous set and clear SHALL leave pend[k]=1.
REQ-018 Eligible(k) SHALL be pend[k] & i_ie[k] & i_ea & level-gate, where level-gate = 0 when high-active, i_ip[k] when only low-active, 1 when none active.
REQ-019 Winner SHALL be the lowest-index eligible source with i_ip=1, else the lowest-index eligible source with i_ip=0.
REQ-020 FSM states: IDLE, OFFER.
REQ-021 IDLE -> OFFER when any source is eligible; winner index and level registered on that edge.
REQ-022 In OFFER: o_irq=1, o_src = registered winner, o_vector = vector(o_src); winner frozen, no re-arbitration.
REQ-023 OFFER -> IDLE without acknowledge when the frozen winner stops being eligible (i_ie, i_ea or level-gate drop); o_irq falls the next cycle; pend unchanged.
REQ-024 OFFER with i_ack=1 -> IDLE; clear pend[winner]; set high-active if winner level=1, else low-active.
REQ-025 i_ack outside OFFER SHALL be ignored.
REQ-026 i_reti SHALL clear high-active if set, else low-active if set, else have no effect.
REQ-027 i_reti and i_ack in the same cycle: RETI clear applied first, then the acknowledge set.
REQ-028 In IDLE, o_irq=0; o_vector and o_src hold last registered values.
REQ-029 Latency: i_req pulse in cycle N (all enables set, no ISR active) -> o_irq=1 in cycle N+2.
REQ-030 A high-level source SHALL preempt an active low-level ISR (nesting depth 2); nothing preempts a high-level ISR.
REQ-031 o_busy = high-active | low-active, registered.

Reset
REQ-032 While i_rst_n=0: pend=0, state=IDLE, o_irq=0, o_vector=16'h0000, o_src=0, high/low-active=0, o_busy=0.
REQ-033 Reset assertion mid-OFFER or mid-ISR SHALL discard all pending and in-service state immediately.

Verification
REQ-034 i_ea=1, i_ie=5'h1F, i_ip=0, i_req[2] pulse cycle 0 -> o_irq=1, o_src=2, o_vector=16'h0013 in cycle 2; i_ack -> pend[2]=0, o_busy=1.
REQ-035 i_req=5'b01010 same cycle, i_ip=0 -> offer src 1 (16'h000B); after ack and i_reti, offer src 3 (16'h001B).
REQ-036 Src 4 low in service; i_req[0] with i_ip[0]=1 -> offer src 0 (16'h0003), ack -> o_lvl_act=2'b11; first i_reti -> 2'b01; second -> 2'b00.
REQ-037 In OFFER for src 1, drop i_ie[1] -> o_irq=0 next cycle, pend[1] still 1; restore i_ie[1] -> re-offer src 1.
REQ-038 i_req[3] pulse in same cycle as ack of src 3 -> pend[3]=1 afterwards, src 3 re-offered after i_reti.
REQ-039 i_rst_n low during OFFER with o_busy=1 -> o_irq, o_busy, pend all 0 without waiting for a clock edge.
